pdsch_dr_tx_pingpong: RTL and testbench

Ping-pong symbol buffer between the PDSCH dimension-reduction core and the CPRI TX repacker. Captures one symbol of beam-domain REs (4 channels × 32 bit per cycle, sop/eop framed) into one of two banks and replays complete symbols to the repacker, gated by the CPRI TX enable. Regenerates the PRB index and sop/eop on the replayed stream. Detects truncated, oversize and overflowing symbols.

---
 rtl/pdsch_dr_tx_pingpong.sv | 363 ++++++++++++++++++++++++++++++++++++
 tb/tb_pdsch_dr_tx_pingpong.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pdsch_dr_tx_pingpong.sv
// -----------------------------------------------------------------------------
// pdsch_dr_tx_pingpong
//
// Ping-pong symbol buffer between the PDSCH dimension-reduction core and the
// CPRI TX repacker. One complete symbol of beam-domain REs (NCH lanes x DW bits
// per word, sop/eop framed) is captured into one of two banks. Complete symbols
// are replayed in write order whenever the CPRI TX side enables them. The PRB
// index and sop/eop are regenerated on the replayed stream. Truncated, oversize
// and overflowing symbols are detected and counted.
//
// Ports
//   i_clk, i_reset        single clock domain, asynchronous active-high reset
//   i_rx_data/vld/sop/eop capture stream from the DR core (channel 0 in LSBs)
//   i_tx_enable           downstream accepts a word this cycle
//   o_tx_data/vld/sop/eop replayed stream (registered)
//   o_prb_idx             PRB index of the current output word
//   o_overflow            1-cycle pulse: symbol dropped, both banks full
//   o_len_err             1-cycle pulse: truncated or oversize symbol
//   o_drop_cnt            saturating count of dropped symbols
//   o_dbg_wr_state        write FSM state (W_IDLE=0, W_FILL=1, W_DISCARD=2)
//   o_dbg_rd_state        read FSM state (R_IDLE=0, R_PLAY=1)
//
// Flow control: the capture side has no back-pressure; a word is taken in
// every cycle with i_rx_vld=1. On the replay side i_tx_enable acts as a ready:
// the read address only advances in cycles with i_tx_enable=1, and each such
// cycle produces exactly one o_tx_vld word two cycles later.
// -----------------------------------------------------------------------------
module pdsch_dr_tx_pingpong #(
  parameter int NCH        = 4,
  parameter int DW         = 32,
  parameter int MAX_PRB    = 132,
  parameter int RE_PER_PRB = 12
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [NCH*DW-1:0] i_rx_data,
  input  logic              i_rx_vld,
  input  logic              i_rx_sop,
  input  logic              i_rx_eop,
  input  logic              i_tx_enable,
  output logic [NCH*DW-1:0] o_tx_data,
  output logic              o_tx_vld,
  output logic              o_tx_sop,
  output logic              o_tx_eop,
  output logic [8:0]        o_prb_idx,
  output logic              o_overflow,
  output logic              o_len_err,
  output logic [15:0]       o_drop_cnt,
  output logic [1:0]        o_dbg_wr_state,
  output logic              o_dbg_rd_state
);

  localparam int DEPTH = MAX_PRB * RE_PER_PRB;  // words per bank
  localparam int AW    = 11;                    // bank address / length width
  localparam int MW    = 12;                    // flat RAM address width
  localparam int WW    = NCH * DW;

  typedef enum logic [1:0] {
    W_IDLE    = 2'd0,
    W_FILL    = 2'd1,
    W_DISCARD = 2'd2
  } wr_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_PLAY = 1'b1
  } rd_state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  wr_state_e           wr_state_q, wr_state_d;
  logic                wr_bank_q, wr_bank_d;
  logic [AW-1:0]       wr_addr_q, wr_addr_d;
  logic [1:0]          full_q, full_d;
  logic [1:0][AW-1:0]  len_q, len_d;
  logic [15:0]         drop_cnt_q, drop_cnt_d;
  logic                overflow_q, overflow_d;
  logic                len_err_q, len_err_d;

  rd_state_e           rd_state_q, rd_state_d;
  logic                rd_bank_q, rd_bank_d;
  logic [AW-1:0]       rd_addr_q, rd_addr_d;
  logic [3:0]          re_cnt_q, re_cnt_d;
  logic [8:0]          prb_cnt_q, prb_cnt_d;

  logic                p1_vld_q, p1_vld_d;
  logic                p1_sop_q, p1_sop_d;
  logic                p1_eop_q, p1_eop_d;
  logic [8:0]          p1_prb_q, p1_prb_d;

  logic                tx_vld_q, tx_vld_d;
  logic                tx_sop_q, tx_sop_d;
  logic                tx_eop_q, tx_eop_d;
  logic [8:0]          tx_prb_q, tx_prb_d;
  logic [WW-1:0]       tx_data_q, tx_data_d;

  // Write-side controls
  logic                mem_we;
  logic [AW-1:0]       mem_waddr;
  logic                drop_inc;
  logic                wr_done;
  logic [AW-1:0]       wr_len;
  logic [1:0]          set_full;

  // Read-side controls
  logic                rd_en;
  logic                issue_sop;
  logic                issue_eop;
  logic [3:0]          cur_re;
  logic [8:0]          cur_prb;
  logic [1:0]          clr_full;

  // RAM
  logic [WW-1:0]       mem [0:2*DEPTH-1];
  logic [WW-1:0]       ram_rdata;
  logic [MW-1:0]       mem_waddr_flat;
  logic [MW-1:0]       mem_raddr_flat;

  // ---------------------------------------------------------------------------
  // Write FSM
  // ---------------------------------------------------------------------------
  always_comb begin : write_fsm
    wr_state_d = wr_state_q;
    wr_bank_d  = wr_bank_q;
    wr_addr_d  = wr_addr_q;
    len_d      = len_q;
    overflow_d = 1'b0;
    len_err_d  = 1'b0;
    drop_inc   = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = '0;
    wr_done    = 1'b0;
    wr_len     = '0;
    set_full   = 2'b00;

    case (wr_state_q)
      W_IDLE, W_DISCARD: begin
        if (i_rx_vld && i_rx_sop) begin
          if (!full_q[wr_bank_q]) begin
            mem_we     = 1'b1;
            mem_waddr  = '0;
            wr_addr_d  = '0;
            wr_state_d = W_FILL;
            if (i_rx_eop) begin
              wr_done = 1'b1;
              wr_len  = AW'(1);
            end
          end else begin
            // Both banks still hold unplayed symbols: drop this one whole.
            overflow_d = 1'b1;
            drop_inc   = 1'b1;
            wr_state_d = i_rx_eop ? W_IDLE : W_DISCARD;
          end
        end else if (wr_state_q == W_DISCARD && i_rx_vld && i_rx_eop) begin
          wr_state_d = W_IDLE;
        end
      end

      W_FILL: begin
        if (i_rx_vld) begin
          if (i_rx_sop) begin
            // Truncated symbol: abandon it and capture the new one in place.
            len_err_d = 1'b1;
            drop_inc  = 1'b1;
            mem_we    = 1'b1;
            mem_waddr = '0;
            wr_addr_d = '0;
            if (i_rx_eop) begin
              wr_done = 1'b1;
              wr_len  = AW'(1);
            end
          end else if (wr_addr_q == AW'(DEPTH - 1)) begin
            // Bank already holds DEPTH words: this word makes it oversize.
            len_err_d  = 1'b1;
            drop_inc   = 1'b1;
            wr_state_d = i_rx_eop ? W_IDLE : W_DISCARD;
          end else begin
            mem_we    = 1'b1;
            mem_waddr = wr_addr_q + AW'(1);
            wr_addr_d = wr_addr_q + AW'(1);
            if (i_rx_eop) begin
              wr_done = 1'b1;
              wr_len  = wr_addr_q + AW'(2);
            end
          end
        end
      end

      default: wr_state_d = W_IDLE;
    endcase

    if (wr_done) begin
      set_full[wr_bank_q] = 1'b1;
      len_d[wr_bank_q]    = wr_len;
      wr_bank_d           = ~wr_bank_q;
      wr_state_d          = W_IDLE;
    end
  end

  always_comb begin : drop_counter
    drop_cnt_d = drop_cnt_q;
    if (drop_inc && drop_cnt_q != 16'hFFFF) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Read FSM
  // ---------------------------------------------------------------------------
  always_comb begin : read_fsm
    rd_state_d = rd_state_q;
    rd_bank_d  = rd_bank_q;
    rd_addr_d  = rd_addr_q;
    re_cnt_d   = re_cnt_q;
    prb_cnt_d  = prb_cnt_q;
    rd_en      = 1'b0;
    issue_sop  = 1'b0;
    issue_eop  = 1'b0;
    cur_re     = '0;
    cur_prb    = '0;
    clr_full   = 2'b00;

    case (rd_state_q)
      R_IDLE: begin
        // Looking at the incoming set as well saves one cycle of latency
        // after the eop write; the RAM write lands before the first read.
        if (full_q[rd_bank_q] || set_full[rd_bank_q]) begin
          rd_state_d = R_PLAY;
          rd_addr_d  = '0;
        end
      end

      R_PLAY: begin
        if (i_tx_enable) begin
          rd_en     = 1'b1;
          issue_sop = (rd_addr_q == '0);
          issue_eop = (rd_addr_q == len_q[rd_bank_q] - AW'(1));
          cur_re    = issue_sop ? 4'd0 : re_cnt_q;
          cur_prb   = issue_sop ? 9'd0 : prb_cnt_q;
          if (cur_re == 4'(RE_PER_PRB - 1)) begin
            re_cnt_d  = '0;
            prb_cnt_d = (cur_prb == 9'(MAX_PRB - 1)) ? 9'd0 : cur_prb + 9'd1;
          end else begin
            re_cnt_d  = cur_re + 4'd1;
            prb_cnt_d = cur_prb;
          end
          if (issue_eop) begin
            clr_full[rd_bank_q] = 1'b1;
            rd_bank_d           = ~rd_bank_q;
            rd_state_d          = R_IDLE;
          end else begin
            rd_addr_d = rd_addr_q + AW'(1);
          end
        end
      end

      default: rd_state_d = R_IDLE;
    endcase
  end

  // Set and clear always target different banks, so both apply together.
  always_comb begin : full_flags
    full_d = (full_q | set_full) & ~clr_full;
  end

  // ---------------------------------------------------------------------------
  // Output pipeline: stage 1 aligns with the RAM read, stage 2 registers outputs
  // ---------------------------------------------------------------------------
  always_comb begin : pipeline
    p1_vld_d  = rd_en;
    p1_sop_d  = issue_sop;
    p1_eop_d  = issue_eop;
    p1_prb_d  = rd_en ? cur_prb : p1_prb_q;
    tx_vld_d  = p1_vld_q;
    tx_sop_d  = p1_vld_q & p1_sop_q;
    tx_eop_d  = p1_vld_q & p1_eop_q;
    tx_prb_d  = p1_vld_q ? p1_prb_q : tx_prb_q;
    tx_data_d = p1_vld_q ? ram_rdata : tx_data_q;
  end

  // ---------------------------------------------------------------------------
  // Bank RAM: bank 1 occupies the upper DEPTH words
  // ---------------------------------------------------------------------------
  always_comb begin : ram_addr
    mem_waddr_flat = {1'b0, mem_waddr} + (wr_bank_q ? MW'(DEPTH) : MW'(0));
    mem_raddr_flat = {1'b0, rd_addr_q} + (rd_bank_q ? MW'(DEPTH) : MW'(0));
  end

  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      mem[mem_waddr_flat] <= i_rx_data;
    end
    if (rd_en) begin
      ram_rdata <= mem[mem_raddr_flat];
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_state_q <= W_IDLE;
      wr_bank_q  <= 1'b0;
      wr_addr_q  <= '0;
      full_q     <= 2'b00;
      len_q      <= '0;
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
      len_err_q  <= 1'b0;
      rd_state_q <= R_IDLE;
      rd_bank_q  <= 1'b0;
      rd_addr_q  <= '0;
      re_cnt_q   <= '0;
      prb_cnt_q  <= '0;
      p1_vld_q   <= 1'b0;
      p1_sop_q   <= 1'b0;
      p1_eop_q   <= 1'b0;
      p1_prb_q   <= '0;
      tx_vld_q   <= 1'b0;
      tx_sop_q   <= 1'b0;
      tx_eop_q   <= 1'b0;
      tx_prb_q   <= '0;
      tx_data_q  <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      wr_bank_q  <= wr_bank_d;
      wr_addr_q  <= wr_addr_d;
      full_q     <= full_d;
      len_q      <= len_d;
      drop_cnt_q <= drop_cnt_d;
      overflow_q <= overflow_d;
      len_err_q  <= len_err_d;
      rd_state_q <= rd_state_d;
      rd_bank_q  <= rd_bank_d;
      rd_addr_q  <= rd_addr_d;
      re_cnt_q   <= re_cnt_d;
      prb_cnt_q  <= prb_cnt_d;
      p1_vld_q   <= p1_vld_d;
      p1_sop_q   <= p1_sop_d;
      p1_eop_q   <= p1_eop_d;
      p1_prb_q   <= p1_prb_d;
      tx_vld_q   <= tx_vld_d;
      tx_sop_q   <= tx_sop_d;
      tx_eop_q   <= tx_eop_d;
      tx_prb_q   <= tx_prb_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign o_tx_data      = tx_data_q;
  assign o_tx_vld       = tx_vld_q;
  assign o_tx_sop       = tx_sop_q;
  assign o_tx_eop       = tx_eop_q;
  assign o_prb_idx      = tx_prb_q;
  assign o_overflow     = overflow_q;
  assign o_len_err      = len_err_q;
  assign o_drop_cnt     = drop_cnt_q;
  assign o_dbg_wr_state = wr_state_q;
  assign o_dbg_rd_state = rd_state_q;

endmodule

// File: tb/tb_pdsch_dr_tx_pingpong.sv
// -----------------------------------------------------------------------------
// Testbench for pdsch_dr_tx_pingpong: table of symbol scenarios plus
// hand-written overflow / reset sequences, with an expected-word queue that
// is filled while symbols are driven and drained by an output monitor.
// -----------------------------------------------------------------------------
module tb_pdsch_dr_tx_pingpong;

  localparam int NCH   = 4;
  localparam int DW    = 32;
  localparam int WW    = NCH * DW;
  localparam int DEPTH = 1584;
  localparam int EW    = 1 + 1 + 9 + WW;   // {sop, eop, prb, data}

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic          clk = 1'b0;
  logic          rst;
  logic [WW-1:0] rx_data;
  logic          rx_vld, rx_sop, rx_eop;
  logic          tx_enable;
  logic [WW-1:0] tx_data;
  logic          tx_vld, tx_sop, tx_eop;
  logic [8:0]    prb_idx;
  logic          overflow, len_err;
  logic [15:0]   drop_cnt;
  logic [1:0]    dbg_wr_state;
  logic          dbg_rd_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  pdsch_dr_tx_pingpong dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_rx_data      (rx_data),
    .i_rx_vld       (rx_vld),
    .i_rx_sop       (rx_sop),
    .i_rx_eop       (rx_eop),
    .i_tx_enable    (tx_enable),
    .o_tx_data      (tx_data),
    .o_tx_vld       (tx_vld),
    .o_tx_sop       (tx_sop),
    .o_tx_eop       (tx_eop),
    .o_prb_idx      (prb_idx),
    .o_overflow     (overflow),
    .o_len_err      (len_err),
    .o_drop_cnt     (drop_cnt),
    .o_dbg_wr_state (dbg_wr_state),
    .o_dbg_rd_state (dbg_rd_state)
  );

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int tests_run    = 0;
  int tests_failed = 0;

  logic [EW-1:0] exp_q[$];

  int gseq         = 0;
  int eop_cyc      = 0;
  int sop_cyc      = 0;
  int last_eop_cyc = -1;
  int gap_chk      = 0;
  int out_cnt      = 0;
  int ov_cnt       = 0;
  int le_cnt       = 0;
  int exp_drop     = 0;
  int en_mode      = 2;   // 0 always on, 1 one-on/three-off, 2 off
  int en_phase     = 0;

  task automatic check(input string name, input logic [EW-1:0] act,
                       input logic [EW-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [WW-1:0] mk_data(input int g);
    logic [WW-1:0] d;
    for (int c = 0; c < NCH; c++) begin
      d[c*DW +: DW] = {8'(c + 1 + (g % 7) * 16), 24'(g)};
    end
    return d;
  endfunction

  // ---------------------------------------------------------------------------
  // Enable driver
  // ---------------------------------------------------------------------------
  initial begin
    tx_enable = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (en_mode)
        0:       tx_enable = 1'b1;
        1: begin
          tx_enable = (en_phase == 0);
          en_phase  = (en_phase + 1) % 4;
        end
        default: tx_enable = 1'b0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic drive_word(input logic [WW-1:0] d, input logic s, input logic e);
    rx_data = d;
    rx_vld  = 1'b1;
    rx_sop  = s;
    rx_eop  = e;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle(input int n);
    rx_vld = 1'b0;
    rx_sop = 1'b0;
    rx_eop = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Optional truncated fragment (sop, no eop) followed by a main symbol.
  // main_len > DEPTH drives main_len-1 words without eop plus a final eop.
  task automatic drive_symbol(input int pre_len, input int main_len,
                              input bit push_exp);
    logic [WW-1:0] d;
    for (int i = 0; i < pre_len; i++) begin
      drive_word(mk_data(gseq), i == 0, 1'b0);
      gseq++;
    end
    for (int i = 0; i < main_len; i++) begin
      d = mk_data(gseq);
      if (i == main_len - 1) eop_cyc = cyc;
      if (push_exp) exp_q.push_back({i == 0, i == main_len - 1, 9'((i / 12) % 132), d});
      drive_word(d, i == 0, i == main_len - 1);
      gseq++;
    end
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_left", EW'(exp_q.size()), EW'(0));
    exp_q.delete();
    repeat (20) @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Output monitor / scoreboard
  // ---------------------------------------------------------------------------
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (overflow) ov_cnt++;
        if (len_err)  le_cnt++;
        if (tx_vld) begin
          out_cnt++;
          if (tx_sop) begin
            sop_cyc = cyc;
            if (gap_chk != 0 && last_eop_cyc >= 0)
              check("sop_gap", EW'(sop_cyc - last_eop_cyc), EW'(2));
          end
          if (tx_eop) last_eop_cyc = cyc;
          if (exp_q.size() == 0) begin
            check("unexpected_word", EW'(1), EW'(0));
          end else begin
            e = exp_q.pop_front();
            check("word", {tx_sop, tx_eop, prb_idx, tx_data}, e);
          end
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Scenario table
  // ---------------------------------------------------------------------------
  typedef struct {
    int pre_len;
    int main_len;
    int mode;
    bit exp_replay;
    int exp_le;
  } row_t;

  row_t rows[7];

  initial begin
    int base_out, base_ov, base_le, n;

    rows[0] = '{pre_len: 0,   main_len: DEPTH,     mode: 0, exp_replay: 1, exp_le: 0};
    rows[1] = '{pre_len: 100, main_len: DEPTH,     mode: 0, exp_replay: 1, exp_le: 1};
    rows[2] = '{pre_len: 0,   main_len: 1,         mode: 0, exp_replay: 1, exp_le: 0};
    rows[3] = '{pre_len: 0,   main_len: 1601,      mode: 0, exp_replay: 0, exp_le: 1};
    rows[4] = '{pre_len: 0,   main_len: 37,        mode: 1, exp_replay: 1, exp_le: 0};
    rows[5] = '{pre_len: 0,   main_len: 12*5 + 7,  mode: 1, exp_replay: 1, exp_le: 0};
    rows[6] = '{pre_len: 0,   main_len: 2,         mode: 0, exp_replay: 1, exp_le: 0};

    // Reset
    rst     = 1'b1;
    rx_data = '0;
    rx_vld  = 1'b0;
    rx_sop  = 1'b0;
    rx_eop  = 1'b0;
    en_mode = 2;
    repeat (3) @(posedge clk);
    #1;
    check("rst_vld",      EW'(tx_vld),       EW'(0));
    check("rst_sop_eop",  EW'({tx_sop, tx_eop}), EW'(0));
    check("rst_prb",      EW'(prb_idx),      EW'(0));
    check("rst_data",     EW'(tx_data),      EW'(0));
    check("rst_pulses",   EW'({overflow, len_err}), EW'(0));
    check("rst_drop",     EW'(drop_cnt),     EW'(0));
    check("rst_fsm",      EW'({dbg_wr_state, dbg_rd_state}), EW'(0));
    rst = 1'b0;
    drive_idle(3);

    // Table-driven scenarios
    for (int r = 0; r < 7; r++) begin
      en_mode  = rows[r].mode;
      base_out = out_cnt;
      base_ov  = ov_cnt;
      base_le  = le_cnt;
      drive_symbol(rows[r].pre_len, rows[r].main_len, rows[r].exp_replay);
      drive_idle(1);
      exp_drop += rows[r].exp_le;
      wait_drain(10000);
      check("row_len_err", EW'(le_cnt - base_le),  EW'(rows[r].exp_le));
      check("row_overflow", EW'(ov_cnt - base_ov), EW'(0));
      check("row_drop_cnt", EW'(drop_cnt),        EW'(exp_drop));
      check("row_out_words", EW'(out_cnt - base_out),
            EW'(rows[r].exp_replay ? rows[r].main_len : 0));
      check("row_wr_idle", EW'(dbg_wr_state), EW'(0));
      if (rows[r].exp_replay && rows[r].mode == 0)
        check("row_latency", EW'(sop_cyc - eop_cyc), EW'(3));
    end

    // Three back-to-back symbols with TX disabled: the third overflows
    en_mode  = 2;
    drive_idle(2);
    base_out = out_cnt;
    base_ov  = ov_cnt;
    drive_symbol(0, 20, 1'b1);
    drive_symbol(0, 30, 1'b1);
    drive_symbol(0, 40, 1'b0);
    drive_idle(10);
    exp_drop += 1;
    check("ovf_pulse",   EW'(ov_cnt - base_ov),   EW'(1));
    check("ovf_drop",    EW'(drop_cnt),           EW'(exp_drop));
    check("ovf_no_out",  EW'(out_cnt - base_out), EW'(0));
    last_eop_cyc = -1;
    gap_chk      = 1;
    en_mode      = 0;
    wait_drain(2000);
    gap_chk      = 0;
    check("ovf_replayed", EW'(out_cnt - base_out), EW'(50));

    // Reset in the middle of a replay
    en_mode  = 0;
    base_out = out_cnt;
    drive_symbol(0, DEPTH, 1'b1);
    drive_idle(1);
    n = 0;
    while (out_cnt - base_out < 500 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("mid_reached", EW'(out_cnt - base_out >= 500), EW'(1));
    #2;
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("mid_rst_vld",  EW'({tx_vld, tx_sop, tx_eop}), EW'(0));
    check("mid_rst_data", EW'({prb_idx, tx_data}),       EW'(0));
    check("mid_rst_misc", EW'({overflow, len_err, drop_cnt}), EW'(0));
    check("mid_rst_fsm",  EW'({dbg_wr_state, dbg_rd_state}), EW'(0));
    exp_drop = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive_idle(3);
    base_out = out_cnt;
    drive_symbol(0, 200, 1'b1);
    drive_idle(1);
    wait_drain(2000);
    check("post_rst_words", EW'(out_cnt - base_out), EW'(200));
    check("post_rst_drop",  EW'(drop_cnt),           EW'(exp_drop));
    check("post_rst_lat",   EW'(sop_cyc - eop_cyc),  EW'(3));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
